fifo_param: RTL and testbench

Parametrised synchronous FIFO: the next-generation buffer for the per-lane transmit-path FIFOs. It generalises depth and width, and accepts simultaneous read/write at the full and empty boundaries. Overflow and underflow are blocked and latched in a sticky error. Almost-full and almost-empty are threshold comparisons (not equality), and a fill-level output is provided. It sits between the lane arbiter (writer) and the lane serialiser logic (reader), one instance per channel.

---
 rtl/fifo_param_if.sv | 29 ++
 rtl/fifo_param.sv | 95 +++++++++
 tb/tb_fifo_param.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a lane FIFO and its writer/reader.
// The master modport is the driving side; the slave modport is the FIFO.
interface fifo_param_if #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 2
);
   logic                  wr_enable;
   logic                  rd_enable;
   logic [DATA_WIDTH-1:0] data_in;
   logic [ADDR_WIDTH:0]   umbral_full;
   logic [ADDR_WIDTH:0]   umbral_empty;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  error;
   logic [ADDR_WIDTH:0]   fill_level;

   modport master (
      output wr_enable, rd_enable, data_in, umbral_full, umbral_empty,
      input  data_out, valid_out, full, empty, almost_full, almost_empty, error, fill_level
   );
   modport slave (
      input  wr_enable, rd_enable, data_in, umbral_full, umbral_empty,
      output data_out, valid_out, full, empty, almost_full, almost_empty, error, fill_level
   );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous lane FIFO with sticky overflow/underflow error and threshold flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle read.
module fifo_param #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 2
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         init_i,
   fifo_param_if.slave  fifo_s
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  error_q, error_d;
   logic                  clr, full, empty, rd_acc, wr_acc;

   assign clr    = reset_i | ~init_i;
   assign full   = (count_q == CNT_DEPTH);
   assign empty  = (count_q == '0);
   assign rd_acc = fifo_s.rd_enable & ~empty;
   // At full a same-cycle accepted read frees the slot for the write.
   assign wr_acc = fifo_s.wr_enable & (~full | rd_acc);

   always_comb begin
      wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      error_d = error_q
              | (fifo_s.wr_enable & full & ~rd_acc)
              | (fifo_s.rd_enable & empty);
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         error_q  <= error_d;
      end
   end

   // Storage is deliberately not cleared; the pointers define what is live.
   always_ff @(posedge clk_i) begin
      if (!clr && wr_acc) mem_q[wr_ptr_q] <= fifo_s.data_in;
   end

`ifdef FIFO_FWFT_EN
   assign fifo_s.data_out  = empty ? '0 : mem_q[rd_ptr_q];
   assign fifo_s.valid_out = ~empty;
`else
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  vld_q, vld_d;

   always_comb begin
      dout_d = rd_acc ? mem_q[rd_ptr_q] : '0;
      vld_d  = rd_acc;
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         vld_q  <= vld_d;
      end
   end

   assign fifo_s.data_out  = dout_q;
   assign fifo_s.valid_out = vld_q;
`endif

   assign fifo_s.full         = full;
   assign fifo_s.empty        = empty;
   assign fifo_s.fill_level   = count_q;
   assign fifo_s.error        = error_q;
   assign fifo_s.almost_full  = (fifo_s.umbral_full == '0) | (count_q >= fifo_s.umbral_full);
   assign fifo_s.almost_empty = (fifo_s.umbral_empty >= CNT_DEPTH) | (count_q <= fifo_s.umbral_empty);
endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: queue-based reference model, directed cases then random traffic.
module tb_fifo_param;
   localparam int DW = 6;
   localparam int AW = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset, init;
   always #5 clk = ~clk;

   fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .reset_i(reset), .init_i(init), .fifo_s(bus.slave)
   );

   int total = 0;
   int bad = 0;
   bit mon_en = 0;

   logic [DW-1:0] m[$];      // words held by the FIFO, oldest first
   logic [DW-1:0] exp_q[$];  // words expected on data_out (registered build)
   bit merr = 0;
   bit ev = 0;               // registered build: valid_out expected this cycle

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
      end
   endfunction

   task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d,
                      input bit rs = 0, input bit in_n = 1);
      bit clr, racc, wacc;
      logic [DW-1:0] front;
      bus.wr_enable = w;
      bus.rd_enable = r;
      bus.data_in   = d;
      reset = rs;
      init  = in_n;
      clr  = rs || !in_n;
      racc = r && (m.size() > 0);
      wacc = w && ((m.size() < DEPTH) || racc);
      @(posedge clk);
      if (clr) begin
         m.delete();
         exp_q.delete();
         merr = 0;
         ev = 0;
      end else begin
         if ((w && m.size() == DEPTH && !racc) || (r && m.size() == 0)) merr = 1;
         ev = racc;
         if (racc) begin
            front = m.pop_front();
`ifndef FIFO_FWFT_EN
            exp_q.push_back(front);
`endif
         end
         if (wacc) m.push_back(d);
      end
      #1;
   endtask

   // Monitor: compares every DUT output against the model away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         int cnt;
         bit af, ae;
         cnt = m.size();
         af = (bus.umbral_full == 0) || (cnt >= int'(bus.umbral_full));
         ae = (int'(bus.umbral_empty) >= DEPTH) || (cnt <= int'(bus.umbral_empty));
         chk("fill_level", 32'(bus.fill_level), cnt);
         chk("full", 32'(bus.full), 32'(cnt == DEPTH));
         chk("empty", 32'(bus.empty), 32'(cnt == 0));
         chk("almost_full", 32'(bus.almost_full), 32'(af));
         chk("almost_empty", 32'(bus.almost_empty), 32'(ae));
         chk("error", 32'(bus.error), 32'(merr));
`ifdef FIFO_FWFT_EN
         chk("valid_out", 32'(bus.valid_out), 32'(cnt != 0));
         chk("data_out", 32'(bus.data_out), cnt != 0 ? 32'(m[0]) : 32'd0);
`else
         chk("valid_out", 32'(bus.valid_out), 32'(ev));
         if (exp_q.size() > 0) chk("rd_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
         else chk("idle_data", 32'(bus.data_out), 32'd0);
`endif
      end
   end

   initial begin
      reset = 1'b1;
      init  = 1'b1;
      bus.wr_enable = 1'b0;
      bus.rd_enable = 1'b0;
      bus.data_in   = '0;
      bus.umbral_full  = 3'd3;
      bus.umbral_empty = 3'd1;
      cyc(0, 0, 0, 1);
      mon_en = 1;
      cyc(0, 0, 0, 1);

      // Fill then drain in order
      for (int i = 1; i <= 4; i++) cyc(1, 0, DW'(i));
      chk("fill4_level", 32'(bus.fill_level), 32'd4);
      chk("fill4_full", 32'(bus.full), 32'd1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("drained_empty", 32'(bus.empty), 32'd1);
      chk("drained_err", 32'(bus.error), 32'd0);

      // Overflow at full, then simultaneous read/write at full
      for (int i = 1; i <= 4; i++) cyc(1, 0, DW'(8 + i));
      cyc(1, 0, 6'h3F);
      chk("ovf_err", 32'(bus.error), 32'd1);
      chk("ovf_cnt", 32'(bus.fill_level), 32'd4);
      cyc(1, 1, 6'h2A);
      chk("rw_full_cnt", 32'(bus.fill_level), 32'd4);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("ovf_sticky", 32'(bus.error), 32'd1);

      // Underflow with simultaneous write at empty
      cyc(0, 0, 0, 1);
      cyc(1, 1, 6'h15);
      chk("udf_cnt", 32'(bus.fill_level), 32'd1);
      chk("udf_err", 32'(bus.error), 32'd1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);

      // Threshold ramp 0..4, plus the forced-on threshold corners
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, DW'(i + 20));
      bus.umbral_full = 3'd0;
      bus.umbral_empty = 3'd4;
      cyc(0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);
      bus.umbral_full = 3'd3;
      bus.umbral_empty = 3'd1;

      // Pointer wrap then reset with two words buffered
      cyc(1, 0, 6'h31);
      cyc(1, 0, 6'h32);
      for (int i = 0; i < 6; i++) cyc(1, 1, DW'(i + 40));
      cyc(0, 0, 0, 1);
      chk("rst_cnt", 32'(bus.fill_level), 32'd0);
      chk("rst_dout", 32'(bus.data_out), 32'd0);
      cyc(1, 0, 6'h07);
      cyc(0, 1, 0);
      cyc(0, 0, 0);

      // Random traffic with occasional clears and threshold changes
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            bus.umbral_full  = 3'($urandom_range(0, 7));
            bus.umbral_empty = 3'($urandom_range(0, 7));
         end
         cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom),
             $urandom_range(0, 99) == 0, $urandom_range(0, 99) != 0);
      end
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
